apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares the single SNN APB register bus among NUM_REQ internal requesters, e.g. testbench sequencer shim, weight loader and config DMA.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases for the granted requester.
- Holds ACCESS through pready wait states and returns read data/response to the granted requester only.
- Bus output is fully protocol-compliant with the team's APB interface checks: psel before penable, penable for one completing cycle, address/data stable.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYC, 16, max ACCESS cycles waiting for pready (used only with APB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester transfer request, held until accepted
- req_ready  out  NUM_REQ  one-hot accept strobe (combinational)
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to owning requester
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 for writes)
- rsp_err  out  1  error flag, valid with rsp_valid
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready

Behaviour:
- Reset (async, rst_n low):
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0.
  - State IDLE.
  - RR pointer set so requester 0 has highest priority.
  - An in-flight transfer is dropped with no rsp_valid; on release the bus restarts from IDLE.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any req_valid, grant g = first set req_valid searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[g]=1 that cycle only.
  - At the clock edge: latch req_write/addr/wdata of g into pwrite/paddr/pwdata, psel<=1, state<=SETUP, last_grant<=g.
- SETUP: psel=1, penable=0 for exactly one cycle; penable<=1, state<=ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata unchanged.
  - On an edge sampling pready=1: psel<=0, penable<=0, rsp_valid[g]<=1 (one cycle), rsp_rdata<=pwrite?0:prdata, rsp_err<=0, state<=IDLE.
  - Wait states (pready=0) are unlimited.
- req_ready is 0 in SETUP/ACCESS; requests there wait and are never lost.
- After completion, IDLE may grant in the same cycle rsp_valid is high. Back-to-back throughput: 3 cycles per transfer with zero wait states.
- Idle bus: paddr/pwdata/pwrite hold last values; psel=penable=0.
- rsp_valid is one-hot or zero; rsp_rdata/rsp_err hold between pulses.
- req_valid dropped by a requester before grant: it is simply not granted; no error.
- NUM_REQ=1 degenerates to a pass-through sequencer.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - ACCESS counter (clog2(TIMEOUT_CYC)+1 bits) clears on entry.
  - If pready is still 0 after TIMEOUT_CYC ACCESS cycles, abort: psel<=0, penable<=0, rsp_valid[g]<=1, rsp_err<=1, rsp_rdata<=0, state<=IDLE.
  - pready=1 on the final counted cycle wins (normal completion).
- APB_TIMEOUT_EN undefined: no counter; rsp_err tied 0; ACCESS waits indefinitely.

Test Plan:
- Single write, req0 addr=0x10 wdata=0xA5A5_0001, pready=1:
  - req_ready[0] at T0; psel at T1 with penable=0; penable at T2; rsp_valid[0] at T3, rsp_err=0.
- Read req2 addr=0x24, slave returns prdata=0xDEAD_BEEF after 3 wait states:
  - penable held 4 cycles with paddr stable.
  - rsp_valid[2] pulse with rsp_rdata=0xDEAD_BEEF.
- All 4 requesters valid continuously from reset: grant order 0,1,2,3,0; each transfer 3 cycles; no requester starved.
- req1 and req3 valid, last_grant=1: req3 granted first, then req1.
- rst_n asserted during ACCESS: psel/penable/rsp_valid go 0 immediately with no clock; no rsp pulse; after release, a pending req0 is served normally.
- APB_TIMEOUT_EN, TIMEOUT_CYC=16, pready stuck 0:
  - Abort after 16 ACCESS cycles; rsp_valid with rsp_err=1, rsp_rdata=0.
  - Next request proceeds normally.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master arbiter: NUM_REQ requesters share one APB bus through IDLE/SETUP/ACCESS.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready (rsp_err=1).
module apb_master_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [DATA_W-1:0]         pwdata,
   input  logic [DATA_W-1:0]         prdata,
   input  logic                      pready
);

   localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic [1:0]         state;
   logic [GW-1:0]      last_grant;
   logic [GW-1:0]      grant;
   logic               grant_found;
   int unsigned        idx;
   logic [NUM_REQ-1:0] grant_oh;
   logic [NUM_REQ-1:0] owner_oh;
   logic               sel_write;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               timed_out;

   // Search starts one past the last grant so every requester gets a turn.
   always_comb begin
      grant       = last_grant;
      grant_found = 1'b0;
      idx         = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant) + k) % NUM_REQ;
         if (!grant_found && req_valid[GW'(idx)]) begin
            grant       = GW'(idx);
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      grant_oh  = '0;
      owner_oh  = '0;
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant == GW'(i)) begin
            grant_oh[i] = 1'b1;
            sel_write   = req_write[i];
            sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata   = req_wdata[i*DATA_W +: DATA_W];
         end
         if (last_grant == GW'(i)) begin
            owner_oh[i] = 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE && grant_found) ? grant_oh : '0;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
   logic [TW-1:0] acc_cnt;
   assign timed_out = (acc_cnt == TW'(TIMEOUT_CYC - 1));
`else
   assign timed_out = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   // last_grant doubles as the owner of the in-flight transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GW'(NUM_REQ - 1);
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
`ifdef APB_TIMEOUT_EN
         rsp_err    <= 1'b0;
         acc_cnt    <= '0;
`endif
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  pwrite     <= sel_write;
                  paddr      <= sel_addr;
                  pwdata     <= sel_wdata;
                  psel       <= 1'b1;
                  last_grant <= grant;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               acc_cnt <= '0;
`endif
            end
            ACCESS: begin
               if (pready || timed_out) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= owner_oh;
                  rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                  state     <= IDLE;
`ifdef APB_TIMEOUT_EN
                  rsp_err   <= !pready;
`endif
               end
`ifdef APB_TIMEOUT_EN
               else begin
                  acc_cnt <= acc_cnt + TW'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: table of single transfers, round-robin, reset-abort and timeout sequences.
module tb_apb_master_arbiter;
   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    req_write = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0]    rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;
   logic             psel, penable, pwrite;
   logic [AW-1:0]    paddr;
   logic [DW-1:0]    pwdata;
   logic [DW-1:0]    prdata = '0;
   logic             pready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int waits    = 0;
   int acc_n    = 0;

   typedef struct {
      int          r;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int          r;
      bit          w;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wt;
   } vec_t;
   vec_t vt[6];

   always #5 clk = ~clk;

   apb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready)
   );

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      if (a == 32'h24) return 32'hDEAD_BEEF;
      return a ^ 32'hA5C3_0F96;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // APB slave: pready rises in ACCESS cycle number 'waits' (0-based).
   always @(negedge clk) begin
      if (psel && penable) begin
         pready = (acc_n == waits);
         acc_n++;
      end else begin
         pready = 1'b0;
         acc_n  = 0;
      end
      prdata = slave_data(paddr);
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (penable) check("psel_with_penable", psel, 1);
      if (rsp_valid != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", rsp_valid, 0);
         end else begin
            e = sb.pop_front();
            check("rsp_valid", rsp_valid, 64'(1) << e.r);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
         end
      end
   end

   task automatic set_req(input int r, input bit w, input logic [31:0] a, input logic [31:0] d);
      req_write[r]          = w;
      req_addr[r*AW +: AW]  = a;
      req_wdata[r*DW +: DW] = d;
   endtask

   task automatic push_exp(input int r, input bit to_err);
      exp_t e;
      e.r     = r;
      e.err   = to_err;
      e.rdata = (to_err || req_write[r]) ? 32'h0 : slave_data(req_addr[r*AW +: AW]);
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at negedge+1 of the cycle where req_ready was seen.
   task automatic wait_grant(input int exp_r, input bit to_err, output int cycles);
      bit ok = 0;
      cycles = -1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (req_ready != '0) begin
            ok = 1;
            cycles = c;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("grant_timeout", 0, 1);
      end else begin
         check("req_ready", req_ready, 64'(1) << exp_r);
         push_exp(exp_r, to_err);
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 60; c++) begin
         if (sb.size() == 0 && !psel) break;
         @(negedge clk);
      end
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic single_xfer(input int r, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input int wt);
      int cyc;
      @(negedge clk);
      waits = wt;
      set_req(r, w, a, d);
      req_valid[r] = 1'b1;
      wait_grant(r, 1'b0, cyc);
      check("grant_latency", cyc, 0);
      @(negedge clk);
      check("setup_psel_penable", {psel, penable}, 2'b10);
      check("setup_paddr", paddr, a);
      check("setup_pwrite", pwrite, w);
      check("setup_pwdata", pwdata, d);
      req_valid[r] = 1'b0;
      for (int k = 0; k <= wt; k++) begin
         @(negedge clk);
         check("access_psel_penable", {psel, penable}, 2'b11);
         check("access_paddr", paddr, a);
      end
      @(negedge clk);
      check("done_psel_penable", {psel, penable}, 2'b00);
      check("done_rsp_valid", rsp_valid, 64'(1) << r);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      int n;
      vt[0] = '{r: 0, w: 1'b1, addr: 32'h10,        wdata: 32'hA5A5_0001, wt: 0};
      vt[1] = '{r: 2, w: 1'b0, addr: 32'h24,        wdata: 32'h0,         wt: 3};
      vt[2] = '{r: 1, w: 1'b0, addr: 32'h100,       wdata: 32'h0,         wt: 0};
      vt[3] = '{r: 3, w: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'hFFFF_FFFF, wt: 1};
      vt[4] = '{r: 0, w: 1'b0, addr: 32'h0,         wdata: 32'h1234_5678, wt: 2};
      vt[5] = '{r: 2, w: 1'b1, addr: 32'h8000_0000, wdata: 32'h0,         wt: 0};

      #2 rst_n = 1'b0;
      #1;
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_req_ready", req_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         single_xfer(vt[i].r, vt[i].w, vt[i].addr, vt[i].wdata, vt[i].wt);
      end
      drain();

      // Round robin from reset with all requesters held valid.
      do_reset();
      waits = 0;
      for (int r = 0; r < NR; r++) set_req(r, (r % 2) == 1, 32'h200 + 32'(r * 4), 32'h1111_0000 + 32'(r));
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         wait_grant(k % NR, 1'b0, cyc);
         if (k > 0) check("rr_spacing", cyc, 2);
         else       check("rr_first_latency", cyc, 0);
      end
      @(negedge clk);
      req_valid = '0;
      drain();

      // last_grant = 1 with req1 and req3 pending: 3 wins, then 1.
      single_xfer(1, 1'b0, 32'h104, 32'h0, 0);
      @(negedge clk);
      set_req(1, 1'b1, 32'h108, 32'h0000_00B1);
      set_req(3, 1'b0, 32'h10C, 32'h0);
      req_valid = 4'b1010;
      wait_grant(3, 1'b0, cyc);
      check("pri_first_latency", cyc, 0);
      @(negedge clk);
      req_valid[3] = 1'b0;
      wait_grant(1, 1'b0, cyc);
      check("pri_second_latency", cyc, 2);
      @(negedge clk);
      req_valid[1] = 1'b0;
      drain();

      // Reset asserted mid-ACCESS with req0 still pending.
      @(negedge clk);
      waits = 5;
      set_req(0, 1'b0, 32'h30, 32'h0);
      req_valid[0] = 1'b1;
      wait_grant(0, 1'b0, cyc);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_penable", penable, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_psel", psel, 0);
      check("async_rst_penable", penable, 0);
      check("async_rst_rsp_valid", rsp_valid, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      waits = 0;
      wait_grant(0, 1'b0, cyc);
      check("post_reset_latency", cyc, 0);
      @(negedge clk);
      req_valid[0] = 1'b0;
      drain();

`ifdef APB_TIMEOUT_EN
      @(negedge clk);
      waits = 1000;
      set_req(1, 1'b0, 32'h40, 32'h0);
      req_valid[1] = 1'b1;
      wait_grant(1, 1'b1, cyc);
      @(negedge clk);
      req_valid[1] = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!penable) break;
         n++;
      end
      check("timeout_access_cycles", n, 16);
      check("timeout_rsp_valid", rsp_valid, 4'b0010);
      check("timeout_rsp_err", rsp_err, 1);
      single_xfer(2, 1'b0, 32'h44, 32'h0, 15);
      single_xfer(3, 1'b1, 32'h48, 32'h0BAD_F00D, 0);
      drain();
`else
      n = 0;
      single_xfer(2, 1'b0, 32'h44, 32'h0, 20);
      drain();
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
